button_press_classifier: RTL
============================

Name: button_press_classifier

Overview:
- Consumes the level output of the early-detection debouncer and turns it into single-cycle event pulses: press, short press, long press and double press.
- Sits directly downstream of the debouncer. Feeds menu/mode logic that needs discrete events rather than a held level.
- All timing is in clock cycles, set by parameters.

Parameters:
- LONG_CYCLES, default 50000000: hold duration (cycles) that classifies a press as long. Legal values >= 2.
- GAP_CYCLES, default 15000000: window after release (cycles) in which a second press makes a double press. Legal values >= 2.

Ports:
- clk_i, input, 1: single clock. All logic is on the rising edge.
- rst_i, input, 1: reset, synchronous, active-high.
- debounced_i, input, 1: debounced button level (1 = pressed).
- press_o, output, 1: one-cycle pulse on every qualified rising edge of debounced_i.
- short_press_o, output, 1: one-cycle pulse when a single short press is classified.
- long_press_o, output, 1: one-cycle pulse when a hold reaches LONG_CYCLES.
- double_press_o, output, 1: one-cycle pulse on release of a second press inside the gap window.

Behaviour:
- Reset:
  - state = IDLE, count = 0, all outputs 0.
  - prev_level register = 1, so a button held through reset must be released before any event is produced.
  - Reset mid-operation discards any partial classification and emits no pulse.
- Registers and latency:
  - All outputs are registered and are high for exactly one cycle per event. No two event outputs are ever high in the same cycle, except press_o with none of the others.
  - Qualified rise = debounced_i==1 && prev_level==0. prev_level <= debounced_i every cycle.
  - press_o is high in the cycle after every qualified rise, in any state.
- Counter:
  - Width is $clog2(max(LONG_CYCLES, GAP_CYCLES)+1).
  - It is cleared on every state entry and never wraps.
- State IDLE:
  - On a qualified rise: count <= 0, go to PRESSED.
  - Otherwise stay in IDLE.
- State PRESSED:
  - If debounced_i==1 and count==LONG_CYCLES-1: long_press_o <= 1, go to LONG_HELD.
  - Else if debounced_i==1: count++.
  - Else (released): count <= 0, go to GAP.
  - Release sampled on the same edge as count==LONG_CYCLES-1 counts as a release, not a long press.
- State LONG_HELD:
  - Stay while debounced_i==1, with no further pulses.
  - On 0, go to IDLE.
- State GAP:
  - On a qualified rise: count <= 0, go to SECOND.
  - Else if count==GAP_CYCLES-1: short_press_o <= 1, go to IDLE.
  - Else count++.
  - A rise on the same edge as count==GAP_CYCLES-1 wins: go to SECOND, no short pulse.
- State SECOND:
  - On debounced_i==0: double_press_o <= 1, go to IDLE.
  - Otherwise stay in SECOND, regardless of hold duration. No long classification in SECOND.
- Timing, with edge E0 being the edge that samples the release in PRESSED:
  - short_press_o is registered at edge E0+GAP_CYCLES.
  - long_press_o is registered LONG_CYCLES edges after the edge that sampled the qualified rise.
- Illegal or unused state encodings go to IDLE with no pulse.

Decomposition:
- Package button_press_classifier_pkg:
  - state_t enum {IDLE, PRESSED, LONG_HELD, GAP, SECOND}, logic [2:0].
  - Localparam helper for the counter width.
- One sub-module, rise_detector: holds the prev_level register with a configurable reset value (1 here) and outputs the qualified-rise strobe. It is reusable by other button consumers.

Test Plan:
All tests use LONG_CYCLES=8, GAP_CYCLES=4.
- Reset behaviour: hold debounced_i=1 through reset and for 20 cycles after -> no pulses at all. Then release, wait 2 cycles, press for 3 cycles and release -> press_o once, short_press_o once, 4 cycles after the release is sampled.
- Short press: 3-cycle press, then idle 10 cycles -> press_o=1 one cycle after the rise, short_press_o exactly once, long_press_o=0, double_press_o=0.
- Long press: hold for 20 cycles -> long_press_o once, 8 edges after the rise edge; nothing on release; no short_press_o.
- Boundary at LONG: release sampled on the 8th edge after the rise -> short path, long_press_o never asserted. A release one edge later -> long_press_o asserted.
- Double press: press 2 cycles, release 2 cycles, press 5 cycles, release -> press_o twice, double_press_o once on the cycle after the second release, no short_press_o.
- Gap boundary: second rise on the 4th edge after the release -> double press. Second rise on the 5th edge -> short_press_o first, then the second press is classified independently (a new press_o, then short_press_o again).

Source files
------------

// File: rtl/button_press_classifier_pkg.sv
// Shared types and sizing helpers for the button press classifier.
package button_press_classifier_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        LONG_HELD = 3'd2,
        GAP       = 3'd3,
        SECOND    = 3'd4
    } state_t;

    // Counter must hold the larger of the two timing thresholds.
    function automatic int cnt_width(input int long_c, input int gap_c);
        return $clog2(((long_c > gap_c) ? long_c : gap_c) + 1);
    endfunction

endpackage

// File: rtl/button_press_classifier_rise_detector.sv
// Qualified rising-edge strobe on a level input; the history register's reset
// value is configurable so a level held through reset can be ignored.
module rise_detector #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) prev_q <= RESET_VAL;
        else       prev_q <= level_i;
    end

    assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/button_press_classifier.sv
// Turns a debounced button level into one-cycle press / short / long / double
// event pulses, with hold and gap durations measured in clock cycles.
module button_press_classifier
    import button_press_classifier_pkg::*;
#(
    parameter int LONG_CYCLES = 50000000,
    parameter int GAP_CYCLES  = 15000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic debounced_i,
    output logic press_o,
    output logic short_press_o,
    output logic long_press_o,
    output logic double_press_o
);

    localparam int CNT_W = cnt_width(LONG_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             press_q, short_q, short_d, long_q, long_d, double_q, double_d;
    logic             rise;

    // Held-through-reset buttons must be released before they can register.
    rise_detector #(.RESET_VAL(1'b1)) u_rise (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .level_i (debounced_i),
        .rise_o  (rise)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    count_d = '0;
                end
            end
            PRESSED: begin
                // A release on the threshold edge takes priority over long.
                if (debounced_i && count_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                    count_d = '0;
                end else if (debounced_i) begin
                    count_d = count_q + CNT_W'(1);
                end else begin
                    state_d = GAP;
                    count_d = '0;
                end
            end
            LONG_HELD: begin
                if (!debounced_i) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            GAP: begin
                if (rise) begin
                    state_d = SECOND;
                    count_d = '0;
                end else if (count_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            SECOND: begin
                if (!debounced_i) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                    count_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            press_q  <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            press_q  <= rise;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
        end
    end

    assign press_o        = press_q;
    assign short_press_o  = short_q;
    assign long_press_o   = long_q;
    assign double_press_o = double_q;

endmodule
